// File: rtl/mem_responder.sv
// mem_responder: word-organised RAM behind the multicycle RV32 core's memory
// port. Handles byte/half/word stores with lane enables. Loads return
// sign/zero-extended data after a fixed READ_LAT cycles. Misaligned requests
// are flagged, are never written, and read back as zero.
module mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int READ_LAT    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic        busy,
   output logic        misalign
);

   localparam int         AW         = $clog2(DEPTH_WORDS);
   localparam logic [2:0] LAST_COUNT = 3'(READ_LAT - 1);

   typedef enum logic {
      IDLE,
      RD
   } state_t;

   state_t state;
   state_t next_state;

   logic [31:0]   mem [DEPTH_WORDS];
   logic [2:0]    count;

   logic [AW-1:0] index;
   logic [1:0]    lane;
   logic          misaligned_req;
   logic          accept_read;
   logic          accept_write;
   logic          write_en;
   logic [3:0]    byte_en;
   logic [31:0]   write_word;

   logic [AW-1:0] rd_index;
   logic [1:0]    rd_lane;
   logic [2:0]    rd_funct3;
   logic          rd_misaligned;

   logic [31:0]   word_data;
   logic [7:0]    load_byte;
   logic [15:0]   load_half;
   logic [31:0]   load_value;

   // Address bits above the RAM size are dropped so addresses wrap.
   logic unused_addr;
   assign unused_addr = ^addr[31:AW+2];

   assign index = addr[AW+1:2];
   assign lane  = addr[1:0];

   // Request decode: misalignment test plus store lane enables and lane-replicated store data.
   always_comb begin
      misaligned_req = ((funct3[1:0] == 2'b01) && lane[0]) ||
                       (funct3[1] && (lane != 2'b00));
      byte_en        = 4'b1111;
      write_word     = wdata;
      case (funct3[1:0])
         2'b00: begin
            byte_en    = 4'b0001 << lane;
            write_word = {4{wdata[7:0]}};
         end
         2'b01: begin
            byte_en    = lane[1] ? 4'b1100 : 4'b0011;
            write_word = {2{wdata[15:0]}};
         end
         default: begin
            byte_en    = 4'b1111;
            write_word = wdata;
         end
      endcase
   end

   // Current FSM state, cleared to IDLE by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state and acceptance. Requests are only seen in IDLE, and a write beats a simultaneous read.
   always_comb begin
      next_state   = state;
      busy         = 1'b0;
      accept_read  = 1'b0;
      accept_write = 1'b0;
      case (state)
         IDLE: begin
            accept_write = mem_write;
            accept_read  = mem_read && !mem_write;
            if (accept_read) begin
               next_state = RD;
            end
         end
         RD: begin
            busy = 1'b1;
            if (count == LAST_COUNT) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign write_en = accept_write && !misaligned_req;

   // RAM store port. Lanes outside the enable keep their contents. The RAM has no reset.
   always_ff @(posedge clk) begin
      if (write_en) begin
         if (byte_en[0]) mem[index][7:0]   <= write_word[7:0];
         if (byte_en[1]) mem[index][15:8]  <= write_word[15:8];
         if (byte_en[2]) mem[index][23:16] <= write_word[23:16];
         if (byte_en[3]) mem[index][31:24] <= write_word[31:24];
      end
   end

   // Load formatting from the request latched at acceptance. Writes are blocked while reading, so the word is stable.
   always_comb begin
      word_data = mem[rd_index];
      case (rd_lane)
         2'd0:    load_byte = word_data[7:0];
         2'd1:    load_byte = word_data[15:8];
         2'd2:    load_byte = word_data[23:16];
         default: load_byte = word_data[31:24];
      endcase
      load_half = rd_lane[1] ? word_data[31:16] : word_data[15:0];
      case (rd_funct3)
         3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
         3'b100:  load_value = {24'd0, load_byte};
         3'b001:  load_value = {{16{load_half[15]}}, load_half};
         3'b101:  load_value = {16'd0, load_half};
         default: load_value = word_data;
      endcase
      if (rd_misaligned) begin
         load_value = 32'd0;
      end
   end

   // Read bookkeeping: latch the request, count the latency, and register rdata/rvalid on the final count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count         <= 3'd0;
         rdata         <= 32'd0;
         rvalid        <= 1'b0;
         misalign      <= 1'b0;
         rd_index      <= '0;
         rd_lane       <= 2'd0;
         rd_funct3     <= 3'd0;
         rd_misaligned <= 1'b0;
      end else begin
         rvalid <= 1'b0;
         if (state == IDLE) begin
            if (accept_read || accept_write) begin
               misalign <= misaligned_req;
            end
            if (accept_read) begin
               count         <= 3'd0;
               rd_index      <= index;
               rd_lane       <= lane;
               rd_funct3     <= funct3;
               rd_misaligned <= misaligned_req;
            end
         end else if (count == LAST_COUNT) begin
            rvalid <= 1'b1;
            rdata  <= load_value;
         end else begin
            count <= count + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed test of mem_responder. The main instance uses
// the default latency. Two side instances with READ_LAT=1 and READ_LAT=4
// check the latency parameter.
module tb_mem_responder;

   logic        clk;
   logic        reset;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [2:0]  funct3;
   logic [31:0] rdata;
   logic        rvalid;
   logic        busy;
   logic        misalign;

   logic        mem_read_x;
   logic        mem_write_x;
   logic [31:0] rdata1, rdata4;
   logic        rvalid1, rvalid4;
   logic        busy1, busy4;
   logic        misalign1, misalign4;

   int checks;
   int failures;

   mem_responder #(.DEPTH_WORDS(1024), .READ_LAT(2)) dut (
      .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .wdata(wdata), .funct3(funct3),
      .rdata(rdata), .rvalid(rvalid), .busy(busy), .misalign(misalign)
   );

   mem_responder #(.DEPTH_WORDS(1024), .READ_LAT(1)) dut_lat1 (
      .clk(clk), .reset(reset), .mem_read(mem_read_x), .mem_write(mem_write_x),
      .addr(addr), .wdata(wdata), .funct3(funct3),
      .rdata(rdata1), .rvalid(rvalid1), .busy(busy1), .misalign(misalign1)
   );

   mem_responder #(.DEPTH_WORDS(1024), .READ_LAT(4)) dut_lat4 (
      .clk(clk), .reset(reset), .mem_read(mem_read_x), .mem_write(mem_write_x),
      .addr(addr), .wdata(wdata), .funct3(funct3),
      .rdata(rdata4), .rvalid(rvalid4), .busy(busy4), .misalign(misalign4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit so a stuck run still terminates.
   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running required=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [2:0] f3);
      mem_read  = rd;
      mem_write = wr;
      addr      = a;
      wdata     = wd;
      funct3    = f3;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic doWrite(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                          input logic exp_mis, input string tag);
      applyStimulus(1'b0, 1'b1, a, wd, f3);
      step();
      applyStimulus(1'b0, 1'b0, a, 32'd0, f3);
      checkOutput({tag, " busy"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, " misalign"}, {31'd0, misalign}, {31'd0, exp_mis});
   endtask

   task automatic doRead(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] exp_data,
                         input logic exp_mis, input string tag);
      int lat;
      lat = 0;
      applyStimulus(1'b1, 1'b0, a, 32'd0, f3);
      step();
      applyStimulus(1'b0, 1'b0, a, 32'd0, f3);
      for (int i = 1; i <= 8 && lat == 0; i++) begin
         step();
         if (rvalid) lat = i;
      end
      checkOutput({tag, " latency"}, 32'(lat), 32'd2);
      checkOutput({tag, " rdata"}, rdata, exp_data);
      checkOutput({tag, " misalign"}, {31'd0, misalign}, {31'd0, exp_mis});
   endtask

   initial begin
      int rv_count;
      int lat1, lat4, pulses1, pulses4;
      logic [31:0] cap1, cap4;

      checks      = 0;
      failures    = 0;
      mem_read_x  = 1'b0;
      mem_write_x = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'b010);

      // Reset values
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
      checkOutput("reset rdata", rdata, 32'd0);
      checkOutput("reset rvalid", {31'd0, rvalid}, 32'd0);
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
      checkOutput("reset misalign", {31'd0, misalign}, 32'd0);

      // Preload through the store port
      doWrite(32'h40, 32'h8081_F2F3, 3'b010, 1'b0, "preload 0x40");
      doWrite(32'h100, 32'h1122_3344, 3'b010, 1'b0, "preload 0x100");

      // LW at 0x40 with mem_read held high through the busy window
      applyStimulus(1'b1, 1'b0, 32'h40, 32'd0, 3'b010);
      step();
      checkOutput("lw k+0 busy", {31'd0, busy}, 32'd1);
      checkOutput("lw k+0 rvalid", {31'd0, rvalid}, 32'd0);
      step();
      checkOutput("lw k+1 busy", {31'd0, busy}, 32'd1);
      checkOutput("lw k+1 rvalid", {31'd0, rvalid}, 32'd0);
      step();
      checkOutput("lw k+2 rvalid", {31'd0, rvalid}, 32'd1);
      checkOutput("lw k+2 busy", {31'd0, busy}, 32'd0);
      checkOutput("lw k+2 rdata", rdata, 32'h8081_F2F3);
      applyStimulus(1'b0, 1'b0, 32'h40, 32'd0, 3'b010);
      step();
      checkOutput("lw k+3 rvalid", {31'd0, rvalid}, 32'd0);
      checkOutput("lw k+3 rdata hold", rdata, 32'h8081_F2F3);

      // Sub-word loads and extension
      doRead(32'h40, 3'b000, 32'hFFFF_FFF3, 1'b0, "lb 0x40");
      doRead(32'h41, 3'b100, 32'h0000_00F2, 1'b0, "lbu 0x41");
      doRead(32'h42, 3'b001, 32'hFFFF_8081, 1'b0, "lh 0x42");
      doRead(32'h42, 3'b101, 32'h0000_8081, 1'b0, "lhu 0x42");
      doRead(32'h43, 3'b000, 32'hFFFF_FF80, 1'b0, "lb 0x43");

      // Sub-word stores; the read is accepted on the edge right after the store
      doWrite(32'h101, 32'h0000_00AA, 3'b000, 1'b0, "sb 0x101");
      doRead(32'h100, 3'b010, 32'h1122_AA44, 1'b0, "lw after sb");
      doWrite(32'h102, 32'h0000_BEEF, 3'b001, 1'b0, "sh 0x102");
      doRead(32'h100, 3'b010, 32'hBEEF_AA44, 1'b0, "lw after sh");

      // Misaligned accesses
      doRead(32'h42, 3'b010, 32'd0, 1'b1, "misaligned lw 0x42");
      doRead(32'h100, 3'b010, 32'hBEEF_AA44, 1'b0, "aligned lw clears");
      doWrite(32'h101, 32'h0000_5555, 3'b001, 1'b1, "misaligned sh 0x101");
      doRead(32'h100, 3'b010, 32'hBEEF_AA44, 1'b0, "ram after misaligned sh");

      // Read and write together: the write wins, no read happens
      applyStimulus(1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF, 3'b010);
      step();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'd0, 3'b010);
      rv_count = 0;
      for (int i = 0; i < 5; i++) begin
         if (rvalid || busy) rv_count++;
         step();
      end
      checkOutput("both-high no read", 32'(rv_count), 32'd0);
      doRead(32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0, "both-high readback");

      // A write pulsed while busy is lost
      applyStimulus(1'b1, 1'b0, 32'h0, 32'd0, 3'b010);
      step();
      applyStimulus(1'b0, 1'b1, 32'h0, 32'h1234_5678, 3'b010);
      step();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'd0, 3'b010);
      step();
      checkOutput("busy-write read rvalid", {31'd0, rvalid}, 32'd1);
      checkOutput("busy-write read rdata", rdata, 32'hDEAD_BEEF);
      doRead(32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0, "ram after busy write");

      // Reset one cycle into a misaligned read
      applyStimulus(1'b1, 1'b0, 32'h42, 32'd0, 3'b010);
      step();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'd0, 3'b010);
      checkOutput("pre-reset misalign", {31'd0, misalign}, 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("mid-read reset rdata", rdata, 32'd0);
      checkOutput("mid-read reset busy", {31'd0, busy}, 32'd0);
      checkOutput("mid-read reset misalign", {31'd0, misalign}, 32'd0);
      step();
      reset = 1'b0;
      rv_count = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (rvalid) rv_count++;
      end
      checkOutput("aborted read rvalid count", 32'(rv_count), 32'd0);

      // Latency parameter: READ_LAT=1 and READ_LAT=4 instances
      applyStimulus(1'b0, 1'b0, 32'h8, 32'hCAFE_F00D, 3'b010);
      mem_write_x = 1'b1;
      step();
      mem_write_x = 1'b0;
      mem_read_x  = 1'b1;
      step();
      mem_read_x = 1'b0;
      lat1 = 0; lat4 = 0; pulses1 = 0; pulses4 = 0;
      cap1 = 32'd0; cap4 = 32'd0;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (rvalid1) begin
            pulses1++;
            if (lat1 == 0) begin lat1 = i; cap1 = rdata1; end
         end
         if (rvalid4) begin
            pulses4++;
            if (lat4 == 0) begin lat4 = i; cap4 = rdata4; end
         end
      end
      checkOutput("lat1 latency", 32'(lat1), 32'd1);
      checkOutput("lat1 pulses", 32'(pulses1), 32'd1);
      checkOutput("lat1 rdata", cap1, 32'hCAFE_F00D);
      checkOutput("lat4 latency", 32'(lat4), 32'd4);
      checkOutput("lat4 pulses", 32'(pulses4), 32'd1);
      checkOutput("lat4 rdata", cap4, 32'hCAFE_F00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
